cordic_iter_sequencer: RTL and testbench
========================================

# cordic_iter_sequencer

Iteration sequencer for the hyperbolic CORDIC datapath of the natural-logarithm unit. It sits directly upstream of the CORDIC control FSM and generates the iteration index (`CONT_ITER`) that the FSM compares against to terminate. The same index drives the barrel-shift amount and the atanh(2^-i) LUT address. It implements the hyperbolic convergence rule: iterations 4 and 13 are executed twice. Each pass advances on a single-cycle `STEP` pulse from the FSM and is flagged with `REPEAT`, `LAST` and a completion pulse.

## Interface
Parameters:
- `N_ITER`, 15: final shift index i. Legal range 4..31.
- `W`, 5: width of `CONT_ITER`. Must satisfy 2^W > `N_ITER`.

Ports:
- `CLK`, in, 1: system clock, rising-edge.
- `RST`, in, 1: synchronous, active-high reset.
- `START`, in, 1: one-cycle pulse that loads the first iteration.
- `STEP`, in, 1: one-cycle pulse from the FSM that closes the current pass and advances to the next.
- `CONT_ITER`, out, W: current iteration index i, which is also the shift amount.
- `LUT_ADDR`, out, W: `CONT_ITER` − 1 (atanh table address); forced to 0 when `CONT_ITER` = 0.
- `REPEAT`, out, 1: the current pass is the second execution of index 4 or 13.
- `LAST`, out, 1: the current pass is the final one.
- `BUSY`, out, 1: the sequencer is in state RUN.
- `DONE`, out, 1: one-cycle pulse after the final pass is stepped.
- `PASS_CNT`, out, 6: number of passes completed since `START`.

## Operation
- Registered FSM with three states: IDLE, RUN, FIN. All outputs are registered or decoded from registers only, with no combinational path from inputs to outputs.
- Reset (`RST`=1 at a clock edge, highest priority in any state):
  - state goes to IDLE;
  - `CONT_ITER`=0, `LUT_ADDR`=0, `REPEAT`=0, `LAST`=0, `BUSY`=0, `DONE`=0, `PASS_CNT`=0.
- IDLE:
  - `START` loads `CONT_ITER`=1, `REPEAT`=0, `PASS_CNT`=0 and moves to RUN.
  - `STEP` is ignored.
  - `CONT_ITER` holds its last value, so the FSM can still read the final index.
- RUN, on `STEP`:
  - if `LAST`=1: move to FIN; `CONT_ITER` and `REPEAT` hold; `PASS_CNT`+1.
  - else if `CONT_ITER`∈{4,13} and `REPEAT`=0: `REPEAT`=1, `CONT_ITER` holds, `PASS_CNT`+1.
  - else: `CONT_ITER`+1, `REPEAT`=0, `PASS_CNT`+1.
- FIN: `DONE`=1 for exactly one cycle, `BUSY`=0, then unconditionally move to IDLE. A `START` in FIN is honoured (load, go to RUN).
- `LAST` decode: `CONT_ITER`=`N_ITER`, and additionally `REPEAT`=1 if `N_ITER`∈{4,13}.
- Index 13 is repeated only when `N_ITER` ≥ 13. Index 40 never occurs.
- `START` in RUN restarts the sequence, reloading as in IDLE.
- `START` and `STEP` in the same cycle: `START` wins and `STEP` is dropped.
- Total passes = `N_ITER` + (`N_ITER`≥4) + (`N_ITER`≥13). For the default this is 17.
- No wrap-around: `CONT_ITER` never exceeds `N_ITER`, and `PASS_CNT` never exceeds the total passes.

## Timing
- `START` at edge k: `BUSY`=1, `CONT_ITER`=1 visible after edge k.
- `STEP` at edge k: the new index, `REPEAT` and `LAST` are visible after edge k. The one-cycle update latency lets the FSM sample them in its next state.
- `STEP` may arrive every cycle. Gaps of any length between steps are legal, and outputs hold during gaps.
- Final `STEP` at edge k: `DONE`=1 during cycle k+1, and `BUSY`=0 from k+1 onward.
- `RST` mid-RUN clears all outputs at the same edge. No `DONE` is issued for the aborted sequence.

## Test plan
- **Default full run** (N_ITER=15): `START`, then 17 `STEP`s on consecutive cycles.
  - `CONT_ITER` sequence: 1,2,3,4,4,5,…,13,13,14,15.
  - `REPEAT`=1 only on the second 4 and the second 13.
  - `LAST`=1 only at 15.
  - `DONE` pulses once the cycle after the 17th `STEP`; `PASS_CNT`=17; `CONT_ITER` holds 15 in IDLE.
- **Sparse steps**: `STEP` every 7 cycles with random gaps → identical sequence to the full run, and all outputs stable between steps.
- **Short sequence** (N_ITER=4): sequence 1,2,3,4,4; `LAST` asserted together with `REPEAT`=1; `DONE` after the 5th `STEP`; `PASS_CNT`=5.
- **Input corner cases**:
  - `STEP` pulses in IDLE and after `DONE` → no change.
  - `START` and `STEP` in the same cycle at `CONT_ITER`=9 → `CONT_ITER`=1, `PASS_CNT`=0.
- **Reset abort**: `RST` asserted while `CONT_ITER`=13 and `REPEAT`=0 → all outputs 0 at the next edge, no `DONE`; a subsequent `START` runs a clean 17-pass sequence.

Source files
------------

// File: rtl/cordic_iter_sequencer.sv
// cordic_iter_sequencer
// Generates the iteration index for the hyperbolic CORDIC loop of the
// natural-logarithm unit. Indices 4 and 13 are executed twice, which the
// hyperbolic rotation needs in order to converge. Each pass is closed by a
// single-cycle STEP pulse from the CORDIC control FSM.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   START      in   one-cycle pulse, loads index 1 (also restarts mid-run)
//   STEP       in   one-cycle pulse, closes the current pass
//   CONT_ITER  out  current iteration index / shift amount
//   LUT_ADDR   out  atanh table address (CONT_ITER-1, 0 when CONT_ITER is 0)
//   REPEAT     out  current pass is the second execution of index 4 or 13
//   LAST       out  current pass is the final pass
//   BUSY       out  sequence in progress
//   DONE       out  one-cycle pulse after the final pass is stepped
//   PASS_CNT   out  passes completed since START
module cordic_iter_sequencer #(
  parameter int N_ITER = 15,
  parameter int W      = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         STEP,
  output logic [W-1:0] CONT_ITER,
  output logic [W-1:0] LUT_ADDR,
  output logic         REPEAT,
  output logic         LAST,
  output logic         BUSY,
  output logic         DONE,
  output logic [5:0]   PASS_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [W-1:0] IDX_LAST = W'(N_ITER);
  localparam logic [W-1:0] IDX_REP_A = W'(32'd4);
  localparam logic [W-1:0] IDX_REP_B = W'(32'd13);
  localparam logic [W-1:0] IDX_FIRST = W'(32'd1);
  // When the final index is itself a repeated one, the final pass is its repeat.
  localparam bit LAST_NEEDS_REPEAT = (N_ITER == 4) || (N_ITER == 13);

  state_t       state_r;
  logic [W-1:0] cont_iter_r;
  logic         repeat_r;
  logic [5:0]   pass_cnt_r;
  logic         last_s;
  logic         rep_idx_s;
  logic [W-1:0] lut_addr_s;

  // Pass-position decode, purely from registered state.
  always_comb begin
    rep_idx_s = (cont_iter_r == IDX_REP_A) || (cont_iter_r == IDX_REP_B);
    if (LAST_NEEDS_REPEAT) begin
      last_s = (cont_iter_r == IDX_LAST) && repeat_r;
    end else begin
      last_s = (cont_iter_r == IDX_LAST);
    end
  end

  // Table address trails the shift index by one; index 0 maps to address 0.
  always_comb begin
    if (cont_iter_r == '0) begin
      lut_addr_s = '0;
    end else begin
      lut_addr_s = cont_iter_r - IDX_FIRST;
    end
  end

  // Sequencer FSM: state, index, repeat flag and pass counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      cont_iter_r <= '0;
      repeat_r    <= 1'b0;
      pass_cnt_r  <= 6'd0;
    end else begin
      case (state_r)
        IDLE, FIN: begin
          // FIN lasts one cycle; START there is honoured like in IDLE.
          if (START) begin
            state_r     <= RUN;
            cont_iter_r <= IDX_FIRST;
            repeat_r    <= 1'b0;
            pass_cnt_r  <= 6'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // START has priority over a coincident STEP.
          if (START) begin
            cont_iter_r <= IDX_FIRST;
            repeat_r    <= 1'b0;
            pass_cnt_r  <= 6'd0;
          end else if (STEP) begin
            pass_cnt_r <= pass_cnt_r + 6'd1;
            if (last_s) begin
              state_r <= FIN;
            end else if (rep_idx_s && !repeat_r) begin
              repeat_r <= 1'b1;
            end else begin
              cont_iter_r <= cont_iter_r + IDX_FIRST;
              repeat_r    <= 1'b0;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign CONT_ITER = cont_iter_r;
  assign LUT_ADDR  = lut_addr_s;
  assign REPEAT    = repeat_r;
  assign LAST      = last_s;
  assign BUSY      = (state_r == RUN);
  assign DONE      = (state_r == FIN);
  assign PASS_CNT  = pass_cnt_r;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Testbench for cordic_iter_sequencer: two instances (N_ITER=15 and N_ITER=4)
// share one clock; expected values come from a pass-list model.
module tb_cordic_iter_sequencer;

  logic       clk;
  logic       rst_s   [2];
  logic       start_s [2];
  logic       step_s  [2];
  logic [4:0] cont_s  [2];
  logic [4:0] lut_s   [2];
  logic       rep_s   [2];
  logic       last_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [5:0] pcnt_s  [2];

  int n_tests = 0;
  int n_fail  = 0;

  cordic_iter_sequencer #(.N_ITER(15), .W(5)) dut_a (
    .CLK(clk), .RST(rst_s[0]), .START(start_s[0]), .STEP(step_s[0]),
    .CONT_ITER(cont_s[0]), .LUT_ADDR(lut_s[0]), .REPEAT(rep_s[0]),
    .LAST(last_s[0]), .BUSY(busy_s[0]), .DONE(done_s[0]), .PASS_CNT(pcnt_s[0])
  );

  cordic_iter_sequencer #(.N_ITER(4), .W(5)) dut_b (
    .CLK(clk), .RST(rst_s[1]), .START(start_s[1]), .STEP(step_s[1]),
    .CONT_ITER(cont_s[1]), .LUT_ADDR(lut_s[1]), .REPEAT(rep_s[1]),
    .LAST(last_s[1]), .BUSY(busy_s[1]), .DONE(done_s[1]), .PASS_CNT(pcnt_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the pass list is every index 1..n in order, with 4 and 13 listed twice.
  function automatic int model_total(input int n);
    return n + ((n >= 4) ? 1 : 0) + ((n >= 13) ? 1 : 0);
  endfunction

  function automatic void model_pass(input int n, input int p, output int idx, output int rep);
    int k;
    k   = 0;
    idx = -1;
    rep = -1;
    for (int i = 1; i <= n; i++) begin
      if (k == p) begin idx = i; rep = 0; return; end
      k++;
      if (i == 4 || i == 13) begin
        if (k == p) begin idx = i; rep = 1; return; end
        k++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // p = passes completed; p == total means the sequence has finished.
  task automatic check_state(input int d, input int n, input int p,
                             input bit busy_exp, input bit done_exp, input string tag);
    int total, pp, idx, rep;
    total = model_total(n);
    pp = (p < total) ? p : total - 1;
    model_pass(n, pp, idx, rep);
    chk({tag, "_cont"}, 32'(cont_s[d]), 32'(idx));
    chk({tag, "_lut"},  32'(lut_s[d]),  32'(idx - 1));
    chk({tag, "_rep"},  32'(rep_s[d]),  32'(rep));
    chk({tag, "_last"}, 32'(last_s[d]), 32'((pp == total - 1) ? 1 : 0));
    chk({tag, "_busy"}, 32'(busy_s[d]), 32'(busy_exp));
    chk({tag, "_done"}, 32'(done_s[d]), 32'(done_exp));
    chk({tag, "_pcnt"}, 32'(pcnt_s[d]), 32'(p));
  endtask

  task automatic check_zero(input int d, input string tag);
    chk({tag, "_cont"}, 32'(cont_s[d]), 32'd0);
    chk({tag, "_lut"},  32'(lut_s[d]),  32'd0);
    chk({tag, "_rep"},  32'(rep_s[d]),  32'd0);
    chk({tag, "_last"}, 32'(last_s[d]), 32'd0);
    chk({tag, "_busy"}, 32'(busy_s[d]), 32'd0);
    chk({tag, "_done"}, 32'(done_s[d]), 32'd0);
    chk({tag, "_pcnt"}, 32'(pcnt_s[d]), 32'd0);
  endtask

  task automatic pulse(input int d, input bit st, input bit sp);
    start_s[d] = st;
    step_s[d]  = sp;
    tick();
    start_s[d] = 1'b0;
    step_s[d]  = 1'b0;
  endtask

  task automatic start_seq(input int d, input int n, input string tag);
    pulse(d, 1'b1, 1'b0);
    check_state(d, n, 0, 1'b1, 1'b0, tag);
  endtask

  // Step only (no final check of DONE); used to reach a mid-sequence point.
  task automatic step_to(input int d, input int n, input int p_from, input int p_to);
    for (int p = p_from + 1; p <= p_to; p++) begin
      pulse(d, 1'b0, 1'b1);
      check_state(d, n, p, 1'b1, 1'b0, "mid");
    end
  endtask

  // Step from pass p0 to completion, with random gaps up to max_gap cycles.
  task automatic run_from(input int d, input int n, input int p0, input int max_gap);
    int total, gap;
    total = model_total(n);
    for (int p = p0 + 1; p <= total; p++) begin
      gap = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check_state(d, n, p - 1, 1'b1, 1'b0, "gap");
      end
      pulse(d, 1'b0, 1'b1);
      if (p < total) check_state(d, n, p, 1'b1, 1'b0, "step");
      else           check_state(d, n, p, 1'b0, 1'b1, "done");
    end
    tick();
    check_state(d, n, total, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    int p9, p13, idx, rep;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; step_s[d] = 1'b0;
    end
    tick(); tick();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    check_zero(0, "rst_a");
    check_zero(1, "rst_b");

    // STEP in IDLE after reset is ignored.
    pulse(0, 1'b0, 1'b1);
    check_zero(0, "idle_step0");

    // Default full run, consecutive steps.
    start_seq(0, 15, "start_full");
    run_from(0, 15, 0, 0);

    // STEP after DONE is ignored; CONT_ITER keeps 15.
    pulse(0, 1'b0, 1'b1);
    check_state(0, 15, 17, 1'b0, 1'b0, "post_done_step");
    pulse(0, 1'b0, 1'b1);
    check_state(0, 15, 17, 1'b0, 1'b0, "post_done_step2");

    // Sparse steps with random gaps.
    start_seq(0, 15, "start_sparse");
    run_from(0, 15, 0, 7);

    // Short sequence on the N_ITER=4 instance: 1,2,3,4,4 with LAST and REPEAT together.
    start_seq(1, 4, "start_short");
    run_from(1, 4, 0, 0);
    start_seq(1, 4, "start_short2");
    run_from(1, 4, 0, 3);

    // START and STEP together at CONT_ITER=9.
    p9 = 0;
    for (int p = 0; p < model_total(15); p++) begin
      model_pass(15, p, idx, rep);
      if (idx == 9 && rep == 0) p9 = p;
    end
    start_seq(0, 15, "start_coll");
    step_to(0, 15, 0, p9);
    chk("coll_at9", 32'(cont_s[0]), 32'd9);
    pulse(0, 1'b1, 1'b1);
    check_state(0, 15, 0, 1'b1, 1'b0, "coll");
    run_from(0, 15, 0, 0);

    // Reset abort at the first pass of index 13.
    p13 = 0;
    for (int p = model_total(15) - 1; p >= 0; p--) begin
      model_pass(15, p, idx, rep);
      if (idx == 13 && rep == 0) p13 = p;
    end
    start_seq(0, 15, "start_abort");
    step_to(0, 15, 0, p13);
    chk("abort_at13", 32'(cont_s[0]), 32'd13);
    chk("abort_rep0", 32'(rep_s[0]),  32'd0);
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    check_zero(0, "abort");
    tick();
    check_zero(0, "abort_nodone");

    // Clean sequence after the abort.
    start_seq(0, 15, "start_after_abort");
    run_from(0, 15, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
